// File: rtl/serial_paralelo_rx_param.sv
// -----------------------------------------------------------------------------
// serial_paralelo_rx_param
//
// Receive-side deserialiser for the PHY. Shifts the serial stream on data_in
// (MSB of each word first) into WIDTH-bit words, bit-aligns on COM_SYMBOL and
// declares the link up after LOCK_COUNT consecutive aligned commas. Once
// locked, every non-comma word is presented on data_out with a one-cycle
// valid strobe. Single clock domain (clk_32f).
//
// Parameters:
//   WIDTH       bits per parallel word (>= 2)
//   COM_SYMBOL  comma/idle word used for alignment (WIDTH bits)
//   LOCK_COUNT  consecutive aligned commas needed for lock (>= 1)
//
// Ports:
//   clk_32f         in   serial bit clock, rising edge active
//   default_values  in   asynchronous active-high reset, clears all state
//   data_in         in   serial data, MSB first
//   data_out        out  [WIDTH-1:0] last received non-comma word
//   valid           out  one-cycle strobe, data_out updated this cycle
//   active          out  link locked (level)
//
// Build option:
//   SP_RX_RELOCK_EN  when defined, a comma seen off the established word
//                    phase while locked drops active and re-runs the lock
//                    sequence on the new phase. When undefined, the bit
//                    phase is fixed once locked and only reset clears active.
// -----------------------------------------------------------------------------
module serial_paralelo_rx_param #(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] COM_SYMBOL = WIDTH'(8'hBC),
   parameter int               LOCK_COUNT = 4
) (
   input  logic             clk_32f,
   input  logic             default_values,
   input  logic             data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             valid,
   output logic             active
);

   localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam int CW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      SYNC   = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   // Only the newest WIDTH-1 bits need storing: every compare is made on
   // sr_next, which appends the bit sampled on the current edge.
   logic [WIDTH-2:0] sr_reg;
   logic [WIDTH-1:0] sr_next;
   logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
   logic [CW-1:0]    com_cnt_reg, com_cnt_next;
   logic [CW-1:0]    com_cnt_inc;
   logic [WIDTH-1:0] data_out_reg, data_out_next;
   logic             valid_reg, valid_next;
   logic             active_reg, active_next;
   logic             at_boundary;
   logic             is_com;

   assign sr_next     = {sr_reg, data_in};
   assign at_boundary = (bit_cnt_reg == BW'(WIDTH - 1));
   assign is_com      = (sr_next == COM_SYMBOL);
   assign com_cnt_inc = com_cnt_reg + 1'b1;

   // State and datapath registers
   always_ff @(posedge clk_32f or posedge default_values) begin
      if (default_values) begin
         state_reg    <= SEARCH;
         sr_reg       <= '0;
         bit_cnt_reg  <= '0;
         com_cnt_reg  <= '0;
         data_out_reg <= '0;
         valid_reg    <= 1'b0;
         active_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         sr_reg       <= sr_next[WIDTH-2:0];
         bit_cnt_reg  <= bit_cnt_next;
         com_cnt_reg  <= com_cnt_next;
         data_out_reg <= data_out_next;
         valid_reg    <= valid_next;
         active_reg   <= active_next;
      end
   end

   // Next-state and output logic
   always_comb begin
      state_next    = state_reg;
      bit_cnt_next  = at_boundary ? '0 : bit_cnt_reg + 1'b1;
      com_cnt_next  = com_cnt_reg;
      data_out_next = data_out_reg;
      valid_next    = 1'b0;
      active_next   = active_reg;

      unique case (state_reg)
         SEARCH: begin
            // Sliding compare on every edge; a hit fixes the word phase so
            // that the next boundary falls WIDTH edges later.
            if (is_com) begin
               bit_cnt_next = '0;
               com_cnt_next = CW'(1);
               if (LOCK_COUNT == 1) begin
                  state_next  = ACTIVE;
                  active_next = 1'b1;
               end else begin
                  state_next = SYNC;
               end
            end
         end

         SYNC: begin
            if (at_boundary) begin
               if (is_com) begin
                  com_cnt_next = com_cnt_inc;
                  if (com_cnt_inc == CW'(LOCK_COUNT)) begin
                     state_next  = ACTIVE;
                     active_next = 1'b1;
                  end
               end else begin
                  // Wrong phase (possibly a comma pattern straddling data):
                  // restart the search on the following edge.
                  state_next   = SEARCH;
                  com_cnt_next = '0;
               end
            end
         end

         ACTIVE: begin
            if (at_boundary) begin
               if (!is_com) begin
                  data_out_next = sr_next;
                  valid_next    = 1'b1;
               end
            end
`ifdef SP_RX_RELOCK_EN
            else if (is_com) begin
               // Comma off the current phase: adopt the new phase and
               // count it as the first comma of a fresh lock sequence.
               bit_cnt_next = '0;
               com_cnt_next = CW'(1);
               if (LOCK_COUNT == 1) begin
                  state_next  = ACTIVE;
                  active_next = 1'b1;
               end else begin
                  state_next  = SYNC;
                  active_next = 1'b0;
               end
            end
`endif
         end

         default: begin
            state_next   = SEARCH;
            com_cnt_next = '0;
         end
      endcase
   end

   assign data_out = data_out_reg;
   assign valid    = valid_reg;
   assign active   = active_reg;

endmodule

// File: tb/tb_serial_paralelo_rx_param.sv
// -----------------------------------------------------------------------------
// tb_serial_paralelo_rx_param
//
// Bench for serial_paralelo_rx_param. Two instances share one clock: an 8-bit
// default instance and a 10-bit instance (COM 10'h17C, LOCK_COUNT 2). Each has
// its own reset so the idle one is parked in reset. Stimulus pushes the
// expected word plus the edge number of its strobe into a per-instance queue;
// a monitor on the falling edge pops and compares on every valid pulse.
// -----------------------------------------------------------------------------
module tb_serial_paralelo_rx_param;

   typedef struct {
      logic [9:0]  data;
      int unsigned edge_no;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst8 = 1'b1;
   logic       rst10 = 1'b1;
   logic       data8 = 1'b0;
   logic       data10 = 1'b0;
   logic [7:0] dout8;
   logic [9:0] dout10;
   logic       valid8, active8, valid10, active10;

   int unsigned edge_cnt = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   exp_t        q8[$];
   exp_t        q10[$];

   serial_paralelo_rx_param u_dut8 (
      .clk_32f        (clk),
      .default_values (rst8),
      .data_in        (data8),
      .data_out       (dout8),
      .valid          (valid8),
      .active         (active8)
   );

   serial_paralelo_rx_param #(
      .WIDTH      (10),
      .COM_SYMBOL (10'h17C),
      .LOCK_COUNT (2)
   ) u_dut10 (
      .clk_32f        (clk),
      .default_values (rst10),
      .data_in        (data10),
      .data_out       (dout10),
      .valid          (valid10),
      .active         (active10)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input bit ok, input string name,
                        input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (ok) begin
         n_pass++;
         $display("ok   %-22s got=%0h", name, act);
      end else begin
         $display("FAIL %-22s got=%0h required=%0h", name, act, req);
      end
   endtask

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (valid8) begin
         if (q8.size() == 0) begin
            check(1'b0, "dut8_unexpected_valid", 32'(dout8), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = q8.pop_front();
            check(dout8 == e.data[7:0], "dut8_data", 32'(dout8), 32'(e.data));
            check(edge_cnt == e.edge_no, "dut8_strobe_edge", edge_cnt, e.edge_no);
            check(active8 == 1'b1, "dut8_active_at_valid", 32'(active8), 32'd1);
         end
      end
   end

   always @(negedge clk) begin
      if (valid10) begin
         if (q10.size() == 0) begin
            check(1'b0, "dut10_unexpected_valid", 32'(dout10), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = q10.pop_front();
            check(dout10 == e.data, "dut10_data", 32'(dout10), 32'(e.data));
            check(edge_cnt == e.edge_no, "dut10_strobe_edge", edge_cnt, e.edge_no);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic bit8(input logic b);
      data8 = b;
      @(posedge clk);
      #1;
   endtask

   task automatic word8(input logic [7:0] w, input bit expect_it);
      if (expect_it) q8.push_back('{data: 10'(w), edge_no: edge_cnt + 8});
      for (int i = 7; i >= 0; i--) bit8(w[i]);
   endtask

   task automatic bits10(input logic [9:0] w, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         data10 = w[i];
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push10(input logic [9:0] w, input int unsigned offset);
      q10.push_back('{data: w, edge_no: edge_cnt + offset});
   endtask

   task automatic reset8;
      rst8 = 1'b1;
      data8 = 1'b0;
      @(posedge clk);
      #1;
      rst8 = 1'b0;
   endtask

   task automatic lock8;
      for (int i = 0; i < 4; i++) word8(8'hBC, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout edge=%0d required=<20000", edge_cnt);
      $fatal(1);
   end

   // ---------------- directed tests ----------------
   initial begin
      repeat (2) @(posedge clk);
      #1;
      check(dout8 == 8'h00 && valid8 == 1'b0 && active8 == 1'b0,
            "reset_state8", {dout8, valid8, active8}, 32'd0);
      check(dout10 == 10'h000 && valid10 == 1'b0 && active10 == 1'b0,
            "reset_state10", {dout10, valid10, active10}, 32'd0);
      rst8 = 1'b0;

      // Lock on 4 commas, then one data word 8 cycles later
      for (int i = 0; i < 3; i++) begin
         word8(8'hBC, 1'b0);
         check(active8 == 1'b0, "t1_active_before_lock", 32'(active8), 32'd0);
      end
      word8(8'hBC, 1'b0);
      check(active8 == 1'b1, "t1_active_on_4th_com", 32'(active8), 32'd1);
      word8(8'h55, 1'b1);
      bit8(1'b0);
      reset8();

      // Lock with a 3-bit phase offset, then back-to-back data
      bit8(1'b1); bit8(1'b0); bit8(1'b1);
      lock8();
      check(active8 == 1'b1, "t2_active_offset_lock", 32'(active8), 32'd1);
      word8(8'hA3, 1'b1);
      word8(8'h3C, 1'b1);
      bit8(1'b0);
      reset8();

      // Broken lock sequence, then a full one
      for (int i = 0; i < 3; i++) word8(8'hBC, 1'b0);
      word8(8'h12, 1'b0);
      check(active8 == 1'b0, "t3_active_after_break", 32'(active8), 32'd0);
      for (int i = 0; i < 3; i++) word8(8'hBC, 1'b0);
      check(active8 == 1'b0, "t3_active_3_of_4", 32'(active8), 32'd0);
      word8(8'hBC, 1'b0);
      check(active8 == 1'b1, "t3_active_relocked", 32'(active8), 32'd1);
      word8(8'h77, 1'b1);

      // Commas between data: data_out holds, valid stays low
      word8(8'h11, 1'b1);
      word8(8'hBC, 1'b0);
      check(dout8 == 8'h11 && valid8 == 1'b0, "t4_hold_over_com1",
            {dout8, valid8}, {8'h11, 1'b0});
      word8(8'hBC, 1'b0);
      check(dout8 == 8'h11 && valid8 == 1'b0, "t4_hold_over_com2",
            {dout8, valid8}, {8'h11, 1'b0});
      word8(8'h11, 1'b1);

      // Asynchronous reset mid-word while locked
      for (int i = 0; i < 4; i++) bit8(1'b1);
      rst8 = 1'b1;
      #1;
      check(dout8 == 8'h00 && valid8 == 1'b0 && active8 == 1'b0,
            "t5_async_reset_clear", {dout8, valid8, active8}, 32'd0);
      data8 = 1'b0;
      @(posedge clk);
      #1;
      rst8 = 1'b0;
      lock8();
      check(active8 == 1'b1, "t5_relock_after_reset", 32'(active8), 32'd1);
      word8(8'h3C, 1'b1);
      word8(8'h3C, 1'b1);
      bit8(1'b0);
      rst8 = 1'b1;

      // 10-bit instance: lock, data, then a comma 3 bits off phase
      rst10 = 1'b0;
      bits10(10'h17C, 10);
      check(active10 == 1'b0, "t6_active_after_1st", 32'(active10), 32'd0);
      bits10(10'h17C, 10);
      check(active10 == 1'b1, "t6_active_after_2nd", 32'(active10), 32'd1);
      push10(10'h155, 10);
      bits10(10'h155, 10);

      // Stream: 000, 17C (ends 3 bits off phase), 17C, 2A5.
      // The word on the old phase boundary 10 bits in is 000_0101111.
      push10(10'h02F, 10);
`ifdef SP_RX_RELOCK_EN
      push10(10'h2A5, 33);
`else
      push10(10'h22F, 20);
      push10(10'h254, 30);
`endif
      bits10(10'h000, 3);
      bits10(10'h17C, 10);
`ifdef SP_RX_RELOCK_EN
      check(active10 == 1'b0, "t6_misaligned_drop", 32'(active10), 32'd0);
`else
      check(active10 == 1'b1, "t6_misaligned_kept", 32'(active10), 32'd1);
`endif
      bits10(10'h17C, 10);
      check(active10 == 1'b1, "t6_active_restored", 32'(active10), 32'd1);
      bits10(10'h2A5, 10);
      bits10(10'h000, 1);
      rst10 = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      check(q8.size() == 0, "dut8_queue_drained", q8.size(), 32'd0);
      check(q10.size() == 0, "dut10_queue_drained", q10.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
